// File: rtl/wb_host_initiator.sv
`default_nettype none
// ============================================================================
// Module   : wb_host_initiator
// Purpose  : Wishbone classic-cycle initiator. Takes single or incrementing
//            multi-beat read/write commands on a valid/ready port, runs each
//            beat on the wbm_* bus, and returns one response per beat on a
//            valid/ready port. Each beat has an ack timeout.
// Ports    : wb_clk_i / wb_rst_n_i    clock, async active-low reset
//            cmd_*                    command port (valid/ready)
//            wbm_*                    Wishbone master bus
//            rsp_*                    per-beat response port (valid/ready)
//            busy                     high whenever a command is in flight
// Revision : 1.0  initial release
// ============================================================================
module wb_host_initiator #(
    parameter int LEN_W   = 4,
    parameter int TIMEOUT = 255
) (
    input  logic             wb_clk_i,
    input  logic             wb_rst_n_i,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic             cmd_we,
    input  logic [31:0]      cmd_adr,
    input  logic [31:0]      cmd_dat,
    input  logic [3:0]       cmd_sel,
    input  logic [LEN_W-1:0] cmd_len,
    output logic             wbm_cyc_o,
    output logic             wbm_stb_o,
    output logic             wbm_we_o,
    output logic [3:0]       wbm_sel_o,
    output logic [31:0]      wbm_adr_o,
    output logic [31:0]      wbm_dat_o,
    input  logic             wbm_ack_i,
    input  logic [31:0]      wbm_dat_i,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [31:0]      rsp_dat,
    output logic             rsp_err,
    output logic             rsp_last,
    output logic             busy
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUS  = 2'd1,
        ST_RSP  = 2'd2
    } state_t;

    // Timer value on the last stb cycle a beat may wait before aborting.
    localparam logic [15:0] c_timer_last = 16'(TIMEOUT - 1);

    state_t           r_state;
    state_t           w_state_nxt;

    logic             r_we;
    logic [31:0]      r_adr;
    logic [31:0]      r_dat;
    logic [3:0]       r_sel;
    logic [LEN_W-1:0] r_remaining;
    logic [15:0]      r_timer;
    logic [31:0]      r_rsp_dat;
    logic             r_rsp_err;

    logic             w_cmd_fire;
    logic             w_rsp_fire;
    logic             w_ack;
    logic             w_timeout;
    logic             w_last;

    assign cmd_ready  = (r_state == ST_IDLE);
    assign busy       = (r_state != ST_IDLE);
    assign wbm_cyc_o  = (r_state == ST_BUS);
    assign wbm_stb_o  = (r_state == ST_BUS);
    assign wbm_we_o   = r_we;
    assign wbm_sel_o  = r_sel;
    assign wbm_adr_o  = r_adr;
    assign wbm_dat_o  = r_dat;
    assign rsp_valid  = (r_state == ST_RSP);
    assign rsp_dat    = r_rsp_dat;
    assign rsp_err    = r_rsp_err;

    // An errored beat ends the command regardless of beats remaining.
    assign w_last     = (r_remaining == '0) || r_rsp_err;
    assign rsp_last   = (r_state == ST_RSP) && w_last;

    assign w_cmd_fire = cmd_valid && cmd_ready;
    assign w_rsp_fire = rsp_valid && rsp_ready;
    // Ack only counts while strobing; ack takes priority over timeout.
    assign w_ack      = (r_state == ST_BUS) && wbm_ack_i;
    assign w_timeout  = (r_state == ST_BUS) && !wbm_ack_i && (r_timer == c_timer_last);

    always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
        if (!wb_rst_n_i) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: if (w_cmd_fire)              w_state_nxt = ST_BUS;
            ST_BUS:  if (w_ack || w_timeout)      w_state_nxt = ST_RSP;
            ST_RSP:  if (w_rsp_fire)              w_state_nxt = w_last ? ST_IDLE : ST_BUS;
            default:                              w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
        if (!wb_rst_n_i) begin
            r_we        <= 1'b0;
            r_adr       <= '0;
            r_dat       <= '0;
            r_sel       <= '0;
            r_remaining <= '0;
            r_timer     <= '0;
            r_rsp_dat   <= '0;
            r_rsp_err   <= 1'b0;
        end else begin
            if (w_cmd_fire) begin
                r_we        <= cmd_we;
                r_adr       <= cmd_adr;
                r_dat       <= cmd_dat;
                r_sel       <= cmd_sel;
                r_remaining <= cmd_len;
                r_timer     <= '0;
            end

            if (r_state == ST_BUS) begin
                if (wbm_ack_i) begin
                    r_rsp_dat <= r_we ? 32'h0 : wbm_dat_i;
                    r_rsp_err <= 1'b0;
                end else begin
                    r_timer <= r_timer + 16'd1;
                    if (w_timeout) begin
                        r_rsp_dat <= 32'h0;
                        r_rsp_err <= 1'b1;
                    end
                end
            end

            // Advance to the next beat; address wraps naturally at 2^32.
            if (w_rsp_fire && !w_last) begin
                r_adr       <= r_adr + 32'd4;
                r_remaining <= r_remaining - 1'b1;
                r_timer     <= '0;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_wb_host_initiator.sv
`default_nettype none
// ============================================================================
// Module   : tb_wb_host_initiator
// Purpose  : Self-checking bench for wb_host_initiator with a scoreboard of
//            expected bus beats and responses, plus a simple Wishbone slave
//            whose ack latency is programmable.
// Revision : 1.0  initial release
// ============================================================================
module tb_wb_host_initiator;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cmd_valid, cmd_ready, cmd_we;
    logic [31:0] cmd_adr, cmd_dat;
    logic [3:0]  cmd_sel, cmd_len;
    logic        cyc, stb, we_o;
    logic [3:0]  sel_o;
    logic [31:0] adr_o, dat_o, dat_i;
    logic        ack;
    logic        rsp_valid, rsp_ready, rsp_err, rsp_last, busy;
    logic [31:0] rsp_dat;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    wb_host_initiator #(.LEN_W(4), .TIMEOUT(8)) dut (
        .wb_clk_i   (clk),
        .wb_rst_n_i (rst_n),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_we     (cmd_we),
        .cmd_adr    (cmd_adr),
        .cmd_dat    (cmd_dat),
        .cmd_sel    (cmd_sel),
        .cmd_len    (cmd_len),
        .wbm_cyc_o  (cyc),
        .wbm_stb_o  (stb),
        .wbm_we_o   (we_o),
        .wbm_sel_o  (sel_o),
        .wbm_adr_o  (adr_o),
        .wbm_dat_o  (dat_o),
        .wbm_ack_i  (ack),
        .wbm_dat_i  (dat_i),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_dat    (rsp_dat),
        .rsp_err    (rsp_err),
        .rsp_last   (rsp_last),
        .busy       (busy)
    );

    // Slave: acks in stb cycle slv_delay+1 of a beat (registered), never if slv_never.
    int          slv_delay = 1;
    bit          slv_never = 1'b0;
    int          slv_cnt;
    logic [31:0] rd_key = 32'h0;

    assign dat_i = adr_o ^ rd_key;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ack     <= 1'b0;
            slv_cnt <= 0;
        end else if (stb && !ack) begin
            if (!slv_never && (slv_cnt + 1 == slv_delay)) begin
                ack     <= 1'b1;
                slv_cnt <= 0;
            end else begin
                slv_cnt <= slv_cnt + 1;
            end
        end else begin
            ack     <= 1'b0;
            slv_cnt <= 0;
        end
    end

    typedef struct {
        logic [31:0] adr;
        logic        we;
        logic [3:0]  sel;
        logic [31:0] dat;
    } beat_t;

    typedef struct {
        logic [31:0] dat;
        logic        err;
        logic        last;
    } rsp_t;

    beat_t exp_beats[$];
    rsp_t  exp_rsps[$];

    int stb_cycles = 0;
    int stb_rises  = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Bus and response monitor, sampled on the falling edge.
    initial begin
        logic  prev_stb;
        beat_t b;
        rsp_t  r;
        prev_stb = 1'b0;
        forever begin
            @(negedge clk);
            if (rst_n) begin
                if (stb && !prev_stb) stb_rises++;
                if (stb) stb_cycles++;
                if (stb && ack) begin
                    check("beat_expected", 32'(exp_beats.size() != 0), 32'd1);
                    if (exp_beats.size() != 0) begin
                        b = exp_beats.pop_front();
                        check("beat_cyc", 32'(cyc), 32'd1);
                        check("beat_adr", adr_o, b.adr);
                        check("beat_we",  32'(we_o), 32'(b.we));
                        check("beat_sel", 32'(sel_o), 32'(b.sel));
                        if (b.we) check("beat_dat", dat_o, b.dat);
                    end
                end
                if (rsp_valid && rsp_ready) begin
                    check("rsp_expected", 32'(exp_rsps.size() != 0), 32'd1);
                    if (exp_rsps.size() != 0) begin
                        r = exp_rsps.pop_front();
                        check("rsp_dat",  rsp_dat, r.dat);
                        check("rsp_err",  32'(rsp_err), 32'(r.err));
                        check("rsp_last", 32'(rsp_last), 32'(r.last));
                    end
                end
            end
            prev_stb = stb;
        end
    end

    // mode 0: normal command, 1: expect a single timeout response, 2: no expectations
    task automatic send_cmd(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                            input logic [3:0] sel, input logic [3:0] len, input int mode);
        logic [31:0] a;
        if (mode == 0) begin
            for (int i = 0; i <= int'(len); i++) begin
                a = adr + 32'(4 * i);
                exp_beats.push_back('{a, we, sel, dat});
                exp_rsps.push_back('{(we ? 32'h0 : (a ^ rd_key)), 1'b0, (i == int'(len))});
            end
        end else if (mode == 1) begin
            exp_rsps.push_back('{32'h0, 1'b1, 1'b1});
        end
        cmd_we    = we;
        cmd_adr   = adr;
        cmd_dat   = dat;
        cmd_sel   = sel;
        cmd_len   = len;
        cmd_valid = 1'b1;
        for (int i = 0; i < 20 && !cmd_ready; i++) tick();
        check("cmd_accepted", 32'(cmd_ready), 32'd1);
        tick();
        cmd_valid = 1'b0;
    endtask

    task automatic wait_idle(input int budget);
        bit done;
        done = 1'b0;
        for (int i = 0; i < budget; i++) begin
            if (!busy && !rsp_valid && exp_rsps.size() == 0) begin
                done = 1'b1;
                break;
            end
            tick();
        end
        check("idle_reached", 32'(done), 32'd1);
    endtask

    initial begin
        int s0, r0;
        logic [31:0] d0;
        bit seen;

        rst_n     = 1'b0;
        cmd_valid = 1'b0;
        cmd_we    = 1'b0;
        cmd_adr   = '0;
        cmd_dat   = '0;
        cmd_sel   = '0;
        cmd_len   = '0;
        rsp_ready = 1'b1;
        repeat (3) tick();

        // Reset state
        check("rst_cmd_ready", 32'(cmd_ready), 32'd1);
        check("rst_cyc",       32'(cyc), 32'd0);
        check("rst_stb",       32'(stb), 32'd0);
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_rsp_last",  32'(rsp_last), 32'd0);
        check("rst_busy",      32'(busy), 32'd0);
        check("rst_adr",       adr_o, 32'd0);
        rst_n = 1'b1;
        tick();

        // Single read
        rd_key = 32'h2234_5678;
        slv_delay = 1;
        s0 = stb_cycles;
        send_cmd(1'b0, 32'h3000_0000, 32'h0, 4'hF, 4'd0, 0);
        wait_idle(50);
        check("single_stb_cycles", 32'(stb_cycles - s0), 32'd2);
        check("single_busy_low",   32'(busy), 32'd0);

        // Write burst
        s0 = stb_cycles;
        r0 = stb_rises;
        send_cmd(1'b1, 32'h3000_0010, 32'hA5A5_A5A5, 4'h3, 4'd3, 0);
        wait_idle(100);
        check("burst_stb_cycles", 32'(stb_cycles - s0), 32'd8);
        check("burst_stb_rises",  32'(stb_rises - r0), 32'd4);

        // Timeout: no ack, three beats requested, only one attempted
        slv_never = 1'b1;
        s0 = stb_cycles;
        r0 = stb_rises;
        send_cmd(1'b0, 32'h3000_0100, 32'h0, 4'hF, 4'd2, 1);
        wait_idle(100);
        repeat (10) tick();
        check("timeout_stb_cycles", 32'(stb_cycles - s0), 32'd8);
        check("timeout_stb_rises",  32'(stb_rises - r0), 32'd1);
        check("timeout_cmd_ready",  32'(cmd_ready), 32'd1);
        slv_never = 1'b0;

        // Back-pressure
        slv_delay = 2;
        rsp_ready = 1'b0;
        send_cmd(1'b0, 32'h4000_0000, 32'h0, 4'hF, 4'd1, 0);
        for (int i = 0; i < 50 && !rsp_valid; i++) tick();
        check("bp_rsp_valid_seen", 32'(rsp_valid), 32'd1);
        d0 = rsp_dat;
        check("bp_first_dat", d0, 32'h4000_0000 ^ rd_key);
        repeat (5) begin
            tick();
            check("bp_valid_hold", 32'(rsp_valid), 32'd1);
            check("bp_dat_hold",   rsp_dat, d0);
            check("bp_stb_low",    32'(stb), 32'd0);
        end
        rsp_ready = 1'b1;
        check("bp_stb_low_at_hs", 32'(stb), 32'd0);
        tick();
        check("bp_stb_after_hs", 32'(stb), 32'd1);
        wait_idle(50);

        // Address wrap
        slv_delay = 1;
        send_cmd(1'b0, 32'hFFFF_FFFC, 32'h0, 4'hF, 4'd1, 0);
        wait_idle(50);

        // Ack arriving on the final allowed stb cycle wins over timeout
        slv_delay = 7;
        s0 = stb_cycles;
        send_cmd(1'b0, 32'h5000_0040, 32'h0, 4'hC, 4'd0, 0);
        wait_idle(50);
        check("collide_stb_cycles", 32'(stb_cycles - s0), 32'd8);

        // Reset mid-beat: outputs drop with no clock edge
        slv_never = 1'b1;
        send_cmd(1'b0, 32'h6000_0000, 32'h0, 4'hF, 4'd3, 2);
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (stb) begin
                seen = 1'b1;
                break;
            end
            tick();
        end
        check("rst_mid_stb_seen", 32'(seen), 32'd1);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("rst_mid_cyc",       32'(cyc), 32'd0);
        check("rst_mid_stb",       32'(stb), 32'd0);
        check("rst_mid_rsp_valid", 32'(rsp_valid), 32'd0);
        tick();
        rst_n = 1'b1;
        check("rst_mid_cmd_ready", 32'(cmd_ready), 32'd1);
        slv_never = 1'b0;

        // Recovery read after reset
        slv_delay = 1;
        send_cmd(1'b0, 32'h3000_0020, 32'h0, 4'hF, 4'd0, 0);
        wait_idle(50);
        check("final_beats_drained", 32'(exp_beats.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
